// File: rtl/pattern_sequencer.sv
// Frame-synchronous test-pattern sequencer: shows each pattern for a dwell period,
// inserts black frames between patterns, and supports manual advance requests.
module pattern_sequencer #(
  parameter int NUM_PATTERNS = 4,
  parameter int DWELL_FRAMES = 300,
  parameter int BLANK_FRAMES = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            vsync,
  input  logic                            paused,
  input  logic                            auto_en,
  input  logic                            next_req,
  output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
  output logic                            blank,
  output logic                            frame_tick,
  output logic                            pattern_changed
);

  localparam int SW  = $clog2(NUM_PATTERNS);
  localparam int DCW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam int BCW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  localparam logic [SW-1:0]  SEL_LAST   = SW'(NUM_PATTERNS - 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_FRAMES - 1);
  localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_FRAMES - 1);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [DCW-1:0] dwell_q, dwell_d;
  logic [BCW-1:0] blank_cnt_q, blank_cnt_d;
  logic           pending_q, pending_d;
  logic           vs_q, vs_d;
  logic           nr_q, nr_d;
  logic           primed_q, primed_d;
  logic           frame_tick_q, frame_tick_d;
  logic           changed_q, changed_d;
  logic           nr_edge;
  logic           go_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SHOW;
      sel_q        <= '0;
      dwell_q      <= '0;
      blank_cnt_q  <= '0;
      pending_q    <= 1'b0;
      vs_q         <= 1'b1;
      nr_q         <= 1'b1;
      primed_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      dwell_q      <= dwell_d;
      blank_cnt_q  <= blank_cnt_d;
      pending_q    <= pending_d;
      vs_q         <= vs_d;
      nr_q         <= nr_d;
      primed_q     <= primed_d;
      frame_tick_q <= frame_tick_d;
      changed_q    <= changed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dwell_d     = dwell_q;
    blank_cnt_d = blank_cnt_q;
    vs_d        = vsync;
    nr_d        = next_req;
    primed_d    = 1'b1;
    changed_d   = 1'b0;
    go_blank    = 1'b0;

    // The first cycle after reset only reloads the edge-detect history, so a
    // vsync held low through reset cannot masquerade as a frame start.
    frame_tick_d = primed_q & vs_q & ~vsync;
    nr_edge      = primed_q & ~nr_q & next_req;

    case (state_q)
      SHOW: begin
        if (frame_tick_q) begin
          if (pending_q || (auto_en && !paused && (dwell_q == DWELL_LAST))) begin
            state_d  = BLANK;
            dwell_d  = '0;
            go_blank = 1'b1;
          end else if (!paused && (dwell_q != DWELL_LAST)) begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      BLANK: begin
        if (frame_tick_q) begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d     = SHOW;
            blank_cnt_d = '0;
            sel_d       = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            changed_d   = 1'b1;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SHOW;
    endcase

    // A request arriving alongside the transition it would cause is absorbed by it.
    if (go_blank) begin
      pending_d = 1'b0;
    end else if (nr_edge) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end
  end

  assign pattern_sel     = sel_q;
  assign blank           = (state_q == BLANK);
  assign frame_tick      = frame_tick_q;
  assign pattern_changed = changed_q;

endmodule
